// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron datapath blocks.
package snn_pkg;

    // Width of the neuron membrane state carried in every event.
    localparam int STATE_W  = 8;

    // Timestamp width of the default event layout.
    localparam int EVT_TS_W = 8;

    // Default event layout: timestamp in the upper bits, state in the lower bits.
    typedef struct packed {
        logic [EVT_TS_W-1:0] ts;
        logic [STATE_W-1:0]  state;
    } spike_evt_t;

    // 8-bit increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spike_event_fifo_if.sv
// Bundle between the neuron, the event FIFO and the downstream consumer.
// The slave side is the event FIFO; the master side drives spikes and ready.
interface spike_event_fifo_if #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 8
);
    import snn_pkg::*;

    logic                       spike;
    logic [STATE_W-1:0]         state;
    logic                       out_valid;
    logic                       out_ready;
    logic [TS_W+STATE_W-1:0]    out_data;
    logic [$clog2(DEPTH):0]     level;
    logic [7:0]                 drop_count;
    logic [7:0]                 rate;
    logic                       rate_valid;

    modport slave (
        input  spike, state, out_ready,
        output out_valid, out_data, level, drop_count, rate, rate_valid
    );

    modport master (
        output spike, state, out_ready,
        input  out_valid, out_data, level, drop_count, rate, rate_valid
    );

endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO. The head entry is read straight out of the
// register array, so it is valid the cycle after the write that filled it.
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [WIDTH-1:0]        i_wdata,
    output logic [WIDTH-1:0]        o_rdata,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == FULL_LVL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage write; data needs no reset since level gates its visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/spike_event_fifo.sv
// Turns neuron spikes into timestamped {ts, state} events queued for a
// valid/ready consumer, counts events lost to overflow, and reports the
// spike rate of each completed window.
module spike_event_fifo
    import snn_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int TS_W   = 8,
    parameter int WINDOW = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    spike_event_fifo_if.slave       bus
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int EVT_W = TS_W + STATE_W;
    localparam int WIN_W = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    logic [TS_W-1:0]    r_ts;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [7:0]         r_acc;
    logic [7:0]         r_rate;
    logic               r_rate_valid;
    logic [7:0]         r_drop_count;

    logic               w_spike;
    logic               w_pop;
    logic               w_drop;
    logic               w_full;
    logic               w_empty;
    logic               w_win_end;
    logic [EVT_W-1:0]   w_wdata;
    logic [EVT_W-1:0]   w_rdata;
    logic [LVL_W-1:0]   w_level;

    // Spikes are ignored while reset is held.
    assign w_spike   = bus.spike & ~rst;
    assign w_pop     = ~w_empty & bus.out_ready;
    assign w_drop    = w_spike & w_full & ~w_pop;
    assign w_wdata   = {r_ts, bus.state};
    assign w_win_end = (r_win_cnt == WIN_LAST);

    sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_spike),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // Free-running timestamp; equals k in the k-th cycle after reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    // Overflow drop counter, saturating at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_drop_count <= sat_inc8(r_drop_count);
        end
    end

    // Window counter and spike accumulator; the last cycle's spike is folded
    // into the published rate so every window covers exactly WINDOW cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_cnt    <= '0;
            r_acc        <= '0;
            r_rate       <= '0;
            r_rate_valid <= 1'b0;
        end else begin
            r_rate_valid <= w_win_end;
            if (w_win_end) begin
                r_win_cnt <= '0;
                r_acc     <= '0;
                r_rate    <= w_spike ? sat_inc8(r_acc) : r_acc;
            end else begin
                r_win_cnt <= r_win_cnt + WIN_W'(1);
                if (w_spike) begin
                    r_acc <= sat_inc8(r_acc);
                end
            end
        end
    end

    assign bus.out_valid  = ~w_empty;
    assign bus.out_data   = w_rdata;
    assign bus.level      = w_level;
    assign bus.drop_count = r_drop_count;
    assign bus.rate       = r_rate;
    assign bus.rate_valid = r_rate_valid;

endmodule

// File: tb/tb_spike_event_fifo.sv
// Directed bench for spike_event_fifo: latency, overflow, full-rate
// push/pop, rate windows (WINDOW=100 and a WINDOW=300 saturation copy),
// timestamp wrap and mid-window reset.
module tb_spike_event_fifo;
    import snn_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spike_event_fifo_if #(.DEPTH(8), .TS_W(8)) bus1 ();
    spike_event_fifo_if #(.DEPTH(8), .TS_W(8)) bus2 ();

    // The WINDOW=300 copy sees the same spike stream and always drains.
    assign bus2.spike     = bus1.spike;
    assign bus2.state     = bus1.state;
    assign bus2.out_ready = 1'b1;

    spike_event_fifo #(.DEPTH(8), .TS_W(8), .WINDOW(100)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    spike_event_fifo #(.DEPTH(8), .TS_W(8), .WINDOW(300)) u_dut_w300 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0 (first cycle with rst low, ts=0).
    task automatic do_reset();
        rst            = 1'b1;
        bus1.spike     = 1'b0;
        bus1.state     = 8'h00;
        bus1.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        spike_evt_t ev;
        int p1;
        int p2;
        int first;

        // Reset state
        do_reset();
        check("rst_out_valid",  bus1.out_valid,  0);
        check("rst_level",      bus1.level,      0);
        check("rst_drop",       bus1.drop_count, 0);
        check("rst_rate",       bus1.rate,       0);
        check("rst_rate_valid", bus1.rate_valid, 0);

        // Single spike at cycle 5, state 0x85
        repeat (5) tick();
        bus1.spike = 1'b1;
        bus1.state = 8'h85;
        tick();
        bus1.spike = 1'b0;
        check("single_valid", bus1.out_valid, 1);
        check("single_data",  bus1.out_data,  32'h0585);
        check("single_level", bus1.level,     1);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        check("single_pop_level", bus1.level,     0);
        check("single_pop_valid", bus1.out_valid, 0);

        // Ten spikes into a depth-8 FIFO with no draining
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus1.spike = 1'b1;
            bus1.state = 8'(i + 16);
            tick();
        end
        bus1.spike = 1'b0;
        check("ovf_level", bus1.level,      8);
        check("ovf_drop",  bus1.drop_count, 2);
        tick();
        check("ovf_hold_head", bus1.out_data, 32'h0010);
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain_valid", bus1.out_valid, 1);
            check("ovf_drain_data",  bus1.out_data,  {16'h0, 8'(i), 8'(i + 16)});
            tick();
        end
        bus1.out_ready = 1'b0;
        check("ovf_empty_valid", bus1.out_valid, 0);
        check("ovf_empty_level", bus1.level,     0);

        // Full FIFO with push and pop every cycle
        do_reset();
        check("full_drop_cleared", bus1.drop_count, 0);
        for (int i = 0; i < 8; i++) begin
            bus1.spike = 1'b1;
            bus1.state = 8'(i);
            tick();
        end
        check("full_level", bus1.level, 8);
        bus1.out_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            check("full_pp_head_ts", bus1.out_data[15:8], 32'(j));
            check("full_pp_level",   bus1.level,          8);
            tick();
        end
        bus1.spike     = 1'b0;
        bus1.out_ready = 1'b0;
        check("full_pp_level_end", bus1.level,          8);
        check("full_pp_drop",      bus1.drop_count,     0);
        check("full_pp_head_end",  bus1.out_data[15:8], 20);

        // Rate with a spike every 4th cycle, WINDOW=100
        do_reset();
        bus1.out_ready = 1'b1;
        p1 = 0;
        for (int c = 0; c < 205; c++) begin
            bus1.spike = (c % 4 == 0);
            tick();
            if (bus1.rate_valid) begin
                p1++;
                check("rate4_value", bus1.rate, 25);
                if (p1 == 1) check("rate4_first_cycle", c + 1, 100);
            end
        end
        bus1.spike = 1'b0;
        check("rate4_pulses", p1, 2);

        // Spike held high for 300 cycles: 100 per window, 255 on WINDOW=300
        do_reset();
        bus1.out_ready = 1'b1;
        p1 = 0;
        p2 = 0;
        for (int c = 0; c < 305; c++) begin
            bus1.spike = (c < 300);
            tick();
            if (bus1.rate_valid) begin
                p1++;
                check("rate_hi_value", bus1.rate, 100);
            end
            if (bus2.rate_valid) begin
                p2++;
                check("rate_sat_value", bus2.rate, 255);
                check("rate_sat_cycle", c + 1, 300);
            end
        end
        bus1.spike = 1'b0;
        check("rate_hi_pulses",  p1, 3);
        check("rate_sat_pulses", p2, 1);

        // Timestamp wrap: events at ts 0xFF then 0x00
        do_reset();
        repeat (255) tick();
        bus1.spike = 1'b1;
        bus1.state = 8'hA1;
        tick();
        bus1.state = 8'hA2;
        tick();
        bus1.spike = 1'b0;
        check("wrap_level", bus1.level, 2);
        ev = bus1.out_data;
        check("wrap_ts0",    ev.ts,    32'hFF);
        check("wrap_state0", ev.state, 32'hA1);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        ev = bus1.out_data;
        check("wrap_ts1",    ev.ts,    32'h00);
        check("wrap_state1", ev.state, 32'hA2);
        check("wrap_level1", bus1.level, 1);

        // Reset mid-window with five queued events
        do_reset();
        for (int c = 0; c < 120; c++) begin
            bus1.spike = (c < 2) || (c >= 110 && c < 113);
            bus1.state = 8'(c);
            tick();
        end
        bus1.spike = 1'b0;
        check("mid_level_pre", bus1.level, 5);
        check("mid_rate_pre",  bus1.rate,  2);
        rst        = 1'b1;
        bus1.spike = 1'b1;
        tick();
        rst        = 1'b0;
        bus1.spike = 1'b0;
        check("mid_out_valid",  bus1.out_valid,  0);
        check("mid_level",      bus1.level,      0);
        check("mid_drop",       bus1.drop_count, 0);
        check("mid_rate",       bus1.rate,       0);
        check("mid_rate_valid", bus1.rate_valid, 0);
        first = -1;
        for (int c = 0; c < 105; c++) begin
            tick();
            if (bus1.rate_valid && first < 0) begin
                first = c + 1;
                check("mid_rate_after", bus1.rate, 0);
            end
        end
        check("mid_first_pulse", first, 100);
        check("mid_level_after", bus1.level, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
